// File: rtl/consec_seq_checker_if.sv
// Bundle of per-channel trigger/repeat/complete inputs and checker status outputs.
interface consec_seq_checker_if #(
  parameter int CHANNELS = 1,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]            a;
  logic [CHANNELS-1:0]            b;
  logic [CHANNELS-1:0]            c;
  logic                           clear;
  logic [CHANNELS-1:0]            busy;
  logic [CHANNELS-1:0]            pass;
  logic [CHANNELS-1:0]            fail;
  logic [CHANNELS-1:0]            overlap;
  logic [CHANNELS-1:0][CNT_W-1:0] fail_count;

  modport master (output a, b, c, clear, input busy, pass, fail, overlap, fail_count);
  modport slave  (input a, b, c, clear, output busy, pass, fail, overlap, fail_count);
endinterface

// File: rtl/consec_seq_checker.sv
// Per-channel "a rises, then b for NREP cycles, then c after GAP cycles" checker,
// replicated CHANNELS times with no shared state between channels.
module consec_seq_lane #(
  parameter int NREP  = 2,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             overlap_o,
  output logic [CNT_W-1:0] fail_count_o
);
  localparam int MAXC = (NREP > GAP) ? NREP : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REP, S_WAIT} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             a_q, pass_q, fail_q, overlap_q;
  logic [CNT_W-1:0] fcnt_q;
  logic             trig, pass_d, fail_d;

  assign trig = a_i & ~a_q;

  // Decisive outcomes of this cycle's sample; they become next cycle's pulses.
  always_comb begin
    pass_d = 1'b0;
    fail_d = 1'b0;
    case (state_q)
      S_REP:   fail_d = ~b_i;
      S_WAIT:  if (cnt_q == CW'(GAP-1)) begin
                 pass_d = c_i;
                 fail_d = ~c_i;
               end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      overlap_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      a_q    <= a_i;
      pass_q <= pass_d;
      fail_q <= fail_d;
      case (state_q)
        S_IDLE: if (trig) begin
                  state_q <= S_REP;
                  cnt_q   <= '0;
                end
        S_REP:  if (!b_i) state_q <= S_IDLE;
                else if (cnt_q == CW'(NREP-1)) begin
                  state_q <= S_WAIT;
                  cnt_q   <= '0;
                end else cnt_q <= cnt_q + CW'(1);
        S_WAIT: if (cnt_q == CW'(GAP-1)) state_q <= S_IDLE;
                else cnt_q <= cnt_q + CW'(1);
        default: state_q <= S_IDLE;
      endcase
      // clear wins over a same-cycle set/increment
      if (clear_i) overlap_q <= 1'b0;
      else if (trig && state_q != S_IDLE) overlap_q <= 1'b1;
      if (clear_i) fcnt_q <= '0;
      else if (fail_d && fcnt_q != {CNT_W{1'b1}}) fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign overlap_o    = overlap_q;
  assign fail_count_o = fcnt_q;
endmodule

module consec_seq_checker #(
  parameter int CHANNELS = 1,
  parameter int NREP     = 2,
  parameter int GAP      = 1,
  parameter int CNT_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  consec_seq_checker_if.slave  bus
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    consec_seq_lane #(.NREP(NREP), .GAP(GAP), .CNT_W(CNT_W)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .a_i          (bus.a[g]),
      .b_i          (bus.b[g]),
      .c_i          (bus.c[g]),
      .clear_i      (bus.clear),
      .busy_o       (bus.busy[g]),
      .pass_o       (bus.pass[g]),
      .fail_o       (bus.fail[g]),
      .overlap_o    (bus.overlap[g]),
      .fail_count_o (bus.fail_count[g])
    );
  end
endmodule

// File: tb/tb_consec_seq_checker.sv
// Directed bench: two checker instances (2ch NREP=2 GAP=1; 1ch NREP=3 GAP=2 CNT_W=2).
module tb_consec_seq_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  consec_seq_checker_if #(.CHANNELS(2), .CNT_W(8)) ia ();
  consec_seq_checker_if #(.CHANNELS(1), .CNT_W(2)) ib ();

  consec_seq_checker #(.CHANNELS(2), .NREP(2), .GAP(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ia));
  consec_seq_checker #(.CHANNELS(1), .NREP(3), .GAP(2), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic clr);
    ia.a = a; ia.b = b; ia.c = c; ia.clear = clr;
  endtask

  task automatic drv_b(input logic a, input logic b, input logic c, input logic clr);
    ib.a = a; ib.b = b; ib.c = c; ib.clear = clr;
  endtask

  task automatic chk_b(input string tag, input logic busy, input logic pass,
                       input logic fail, input logic [1:0] cnt);
    chk({tag, ".busy"}, 32'(ib.busy), 32'(busy));
    chk({tag, ".pass"}, 32'(ib.pass), 32'(pass));
    chk({tag, ".fail"}, 32'(ib.fail), 32'(fail));
    chk({tag, ".cnt"},  32'(ib.fail_count[0]), 32'(cnt));
  endtask

  initial begin
    drv_a(2'b00, 2'b00, 2'b00, 1'b0);
    drv_b(1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst.busy", 32'(ia.busy), 32'h0);
    chk("rst.pass", 32'(ia.pass), 32'h0);
    chk("rst.fail", 32'(ia.fail), 32'h0);
    chk("rst.ovl",  32'(ia.overlap), 32'h0);
    chk("rst.cnt",  32'(ia.fail_count), 32'h0);
    rst = 1'b0;
    tick();

    // ---- DUT A: ch0 pass then fail, ch1 overlap then pass ----
    drv_a(2'b11, 2'b00, 2'b00, 1'b0); chk("a1.busy", 32'(ia.busy), 32'h0); tick();
    drv_a(2'b00, 2'b11, 2'b00, 1'b0); chk("a2.busy", 32'(ia.busy), 32'h3); tick();
    drv_a(2'b10, 2'b11, 2'b00, 1'b0); chk("a3.ovl",  32'(ia.overlap), 32'h0); tick();
    drv_a(2'b00, 2'b00, 2'b11, 1'b0);
    chk("a4.busy", 32'(ia.busy), 32'h3);
    chk("a4.ovl",  32'(ia.overlap), 32'h2);
    tick();
    drv_a(2'b01, 2'b00, 2'b00, 1'b0);
    chk("a5.pass", 32'(ia.pass), 32'h3);
    chk("a5.fail", 32'(ia.fail), 32'h0);
    chk("a5.busy", 32'(ia.busy), 32'h0);
    chk("a5.cnt",  32'(ia.fail_count), 32'h0);
    tick();
    drv_a(2'b00, 2'b01, 2'b00, 1'b0);
    chk("a6.busy", 32'(ia.busy), 32'h1);
    chk("a6.pass", 32'(ia.pass), 32'h0);
    tick();
    drv_a(2'b00, 2'b00, 2'b01, 1'b0); chk("a7.busy", 32'(ia.busy), 32'h1); tick();
    drv_a(2'b00, 2'b00, 2'b00, 1'b0);
    chk("a8.fail", 32'(ia.fail), 32'h1);
    chk("a8.pass", 32'(ia.pass), 32'h0);
    chk("a8.busy", 32'(ia.busy), 32'h0);
    chk("a8.cnt0", 32'(ia.fail_count[0]), 32'h1);
    chk("a8.cnt1", 32'(ia.fail_count[1]), 32'h0);
    chk("a8.ovl",  32'(ia.overlap), 32'h2);
    tick();
    drv_a(2'b00, 2'b00, 2'b00, 1'b1);
    chk("a9.fail", 32'(ia.fail), 32'h0);
    chk("a9.busy", 32'(ia.busy), 32'h0);
    tick();
    drv_a(2'b00, 2'b00, 2'b00, 1'b0);
    chk("a10.ovl", 32'(ia.overlap), 32'h0);
    chk("a10.cnt", 32'(ia.fail_count[0]), 32'h0);
    tick();

    // ---- DUT B: NREP=3 GAP=2, c sampled two cycles after last b ----
    drv_b(1, 0, 0, 0); chk_b("b0", 0, 0, 0, 0); tick();
    drv_b(0, 1, 0, 0); chk_b("b1", 1, 0, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(0, 0, 0, 0); chk_b("b4", 1, 0, 0, 0); tick();  // c low in the ignored cycle
    drv_b(0, 0, 1, 0); chk_b("b5", 1, 0, 0, 0); tick();
    drv_b(1, 0, 0, 0); chk_b("b6", 0, 1, 0, 0); tick();  // retrigger on pass cycle
    drv_b(0, 1, 0, 0); chk_b("b7", 1, 0, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(0, 0, 1, 0); tick();
    drv_b(0, 0, 0, 0); chk_b("b11", 1, 0, 0, 0); tick();
    // fail at 12; then quick b-low failures to saturate the 2-bit counter
    for (int k = 0; k < 3; k++) begin
      drv_b(1, 0, 0, 0);
      chk_b($sformatf("bsat%0d", k), 0, 0, 1, (k == 0) ? 2'd1 : 2'(k + 1));
      tick();
      drv_b(0, 0, 0, 0); tick();
    end
    drv_b(1, 0, 0, 0); chk_b("bsat3", 0, 0, 1, 3); tick();
    drv_b(0, 0, 0, 1); chk_b("bclr0", 1, 0, 0, 3); tick();
    drv_b(0, 0, 0, 0); chk_b("bclr1", 0, 0, 1, 0); tick();

    // ---- reset mid-check aborts silently; a high right after reset triggers ----
    drv_b(1, 0, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(1, 1, 1, 0); chk_b("br0", 1, 0, 0, 0);
    rst = 1'b1; #1;
    chk_b("br1", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk_b("br2", 0, 0, 0, 0);
    tick();
    drv_b(0, 1, 0, 0); chk_b("br3", 1, 0, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(0, 1, 0, 0); tick();
    drv_b(0, 0, 0, 0); tick();
    drv_b(0, 0, 1, 0); chk_b("br6", 1, 0, 0, 0); tick();
    drv_b(0, 0, 0, 0); chk_b("br7", 0, 1, 0, 0); tick();
    chk_b("br8", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
